qc_job_dispatcher: RTL and testbench
====================================

Name: qc_job_dispatcher

Overview:
- Shares the single quantum program engine (the microcode scheduler plus state memory) between N_REQ requesters.
- Round-robin arbitration over pending program-run requests.
- Issues a one-cycle start with the selected prog_id, then waits for the engine's done level or a timeout.
- Captures the engine cycle count, clears the engine back to idle, and returns a one-cycle response to the granted requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 4096, RUN-state cycle limit before a job is aborted (>=2).
- JW, 16, width of the completed-jobs counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  N_REQ  per-requester run request, held until req_ready
- req_prog  in  2*N_REQ  prog_id of requester i in bits [2i+1:2i], stable while req_valid
- req_ready  out  N_REQ  one-hot one-cycle accept pulse
- rsp_valid  out  N_REQ  one-hot one-cycle completion pulse
- rsp_status  out  1  0=OK, 1=TIMEOUT; valid with rsp_valid
- rsp_cycles  out  32  engine cycle_count (OK) or TIMEOUT (timeout); valid with rsp_valid
- eng_start  out  1  one-cycle start to engine
- eng_prog_id  out  2  program select, held from LAUNCH until next LAUNCH
- eng_done  in  1  engine done level; stays high until engine cleared
- eng_cycle_count  in  32  engine cycle counter
- eng_clr  out  1  one-cycle request returning the engine to idle
- busy  out  1  high in every state except IDLE
- jobs_done  out  JW  count of responses issued (OK or TIMEOUT), saturating at all-ones

Behaviour:
- Reset values: all outputs 0, rr pointer = 0, timer = 0, state = IDLE. Reset mid-job aborts it: no rsp_valid, no eng_clr.
- States: IDLE, LAUNCH, RUN, CLEAR, RESP.
- IDLE:
  - Grant condition: any req_valid high and eng_done low. If eng_done is high, no grant is made.
  - Winner: first index with req_valid high, searching ptr, ptr+1, ... mod N_REQ.
  - Register winner and req_prog[winner]; go to LAUNCH.
- LAUNCH (1 cycle):
  - req_ready[winner]=1, eng_start=1, eng_prog_id=latched prog.
  - ptr <= (winner+1) mod N_REQ. timer <= 0. Go to RUN.
- RUN:
  - eng_done sampled only here (a done level seen in LAUNCH is ignored).
  - eng_done=1: latch rsp_cycles=eng_cycle_count, status=0, go to CLEAR.
  - Otherwise timer++. If timer == TIMEOUT-1 with eng_done still low: latch rsp_cycles=TIMEOUT, status=1, go to CLEAR.
  - eng_done in the same cycle as the timeout compare: OK wins.
- CLEAR (1 cycle): eng_clr=1. Go to RESP.
- RESP (1 cycle):
  - rsp_valid[winner]=1 with latched status and cycles.
  - jobs_done++ (saturating). Go to IDLE.
- rsp_status and rsp_cycles hold their values until the next RESP.
- Latency:
  - Request visible at cycle T in IDLE -> req_ready/eng_start at T+1.
  - eng_done first high in RUN at cycle D -> eng_clr at D+1, rsp_valid at D+2, IDLE at D+3.
  - Minimum job turnaround is therefore 5 cycles.
- Requests arriving during a job are held by the requester; they are not queued internally.
- Requester protocol:
  - Dropping req_valid before req_ready is a protocol violation.
  - Once winner and prog are registered, the dispatcher completes that job regardless.
- Width rules:
  - Timer is $clog2(TIMEOUT)+1 bits.
  - rsp_cycles is 32 bits, TIMEOUT zero-extended.
  - Pointer wrap is computed mod N_REQ, not as a power of two.

Test Plan:
- Single request 0 with prog 2, engine model asserts done 20 cycles after start with count 57 -> req_ready[0] and eng_start at T+1, eng_prog_id=2, eng_clr at D+1, rsp_valid[0] at D+2, status 0, cycles 57, jobs_done=1.
- All four req_valid high continuously, each engine run completes -> grant order 0,1,2,3,0; every rsp_valid matches its earlier req_ready index.
- Engine never asserts done, TIMEOUT=16 -> eng_clr 16 cycles after RUN entry, rsp_status=1, rsp_cycles=16; the next request is then served normally.
- eng_done held high externally while in IDLE with req_valid[1] high -> no req_ready; grant occurs the cycle after eng_done drops.
- rst pulsed mid-RUN -> all outputs 0 asynchronously, no rsp_valid; after release, pending req_valid[3] is granted first only if ptr=0 finds no lower index pending.
- jobs_done with JW=2 after 5 jobs -> saturates at 3.

Source files
------------

// File: rtl/qc_job_dispatcher.sv
// qc_job_dispatcher
// Round-robin dispatcher that shares one quantum program engine between
// N_REQ requesters: grants a pending request, issues a one-cycle start with
// the requester's prog_id, waits for engine done (or a timeout), clears the
// engine and returns a one-cycle response with the status and cycle count.
module qc_job_dispatcher #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4096,
    parameter int JW      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [2*N_REQ-1:0] req_prog,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic               rsp_status,
    output logic [31:0]        rsp_cycles,
    output logic               eng_start,
    output logic [1:0]         eng_prog_id,
    input  logic               eng_done,
    input  logic [31:0]        eng_cycle_count,
    output logic               eng_clr,
    output logic               busy,
    output logic [JW-1:0]      jobs_done
);

    localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW1 = PW + 1;
    localparam int TW  = $clog2(TIMEOUT) + 1;

    localparam logic [TW-1:0]  TIMER_LAST     = TW'(TIMEOUT - 1);
    localparam logic [31:0]    TIMEOUT_CYCLES = 32'(TIMEOUT);
    localparam logic [PW-1:0]  LAST_IDX       = PW'(N_REQ - 1);
    localparam logic [PW1-1:0] N_REQ_W        = PW1'(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_CLEAR,
        S_RESP
    } state_t;

    state_t         state_reg,  state_next;
    logic [PW-1:0]  ptr_reg,    ptr_next;
    logic [PW-1:0]  winner_reg, winner_next;
    logic [1:0]     prog_reg,   prog_next;
    logic [TW-1:0]  timer_reg,  timer_next;
    logic           status_reg, status_next;
    logic [31:0]    cycles_reg, cycles_next;
    logic [JW-1:0]  jobs_reg,   jobs_next;

    // Rotated view of the requests: offset gi looks at index (ptr+gi) mod N_REQ.
    // The wrap is an explicit subtract so non-power-of-two N_REQ works.
    logic [PW-1:0]    cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_valid;
    logic [PW-1:0]    pick_idx;
    logic             any_pending;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [PW1-1:0] sum;
            assign sum            = {1'b0, ptr_reg} + PW1'(gi);
            assign cand_idx[gi]   = (sum >= N_REQ_W) ? PW'(sum - N_REQ_W) : sum[PW-1:0];
            assign cand_valid[gi] = req_valid[cand_idx[gi]];
        end
    endgenerate

    assign any_pending = |req_valid;

    // Pick the lowest rotation offset with a pending request.
    always_comb begin
        pick_idx = ptr_reg;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                pick_idx = cand_idx[k];
            end
        end
    end

    // Next-state logic and the one-cycle strobes decoded from the state.
    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        winner_next = winner_reg;
        prog_next   = prog_reg;
        timer_next  = timer_reg;
        status_next = status_reg;
        cycles_next = cycles_reg;
        jobs_next   = jobs_reg;
        req_ready   = '0;
        rsp_valid   = '0;
        eng_start   = 1'b0;
        eng_clr     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // An engine still reporting done has not been cleared; hold off.
                if (any_pending && !eng_done) begin
                    winner_next = pick_idx;
                    prog_next   = req_prog[{pick_idx, 1'b0} +: 2];
                    state_next  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                req_ready[winner_reg] = 1'b1;
                eng_start             = 1'b1;
                ptr_next   = (winner_reg == LAST_IDX) ? '0 : winner_reg + 1'b1;
                timer_next = '0;
                state_next = S_RUN;
            end
            S_RUN: begin
                // Done takes priority over a coincident timeout.
                if (eng_done) begin
                    cycles_next = eng_cycle_count;
                    status_next = 1'b0;
                    state_next  = S_CLEAR;
                end else if (timer_reg == TIMER_LAST) begin
                    cycles_next = TIMEOUT_CYCLES;
                    status_next = 1'b1;
                    state_next  = S_CLEAR;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            S_CLEAR: begin
                eng_clr    = 1'b1;
                state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid[winner_reg] = 1'b1;
                if (jobs_reg != '1) begin
                    jobs_next = jobs_reg + 1'b1;
                end
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            ptr_reg    <= '0;
            winner_reg <= '0;
            prog_reg   <= '0;
            timer_reg  <= '0;
            status_reg <= 1'b0;
            cycles_reg <= '0;
            jobs_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            winner_reg <= winner_next;
            prog_reg   <= prog_next;
            timer_reg  <= timer_next;
            status_reg <= status_next;
            cycles_reg <= cycles_next;
            jobs_reg   <= jobs_next;
        end
    end

    assign rsp_status  = status_reg;
    assign rsp_cycles  = cycles_reg;
    assign eng_prog_id = prog_reg;
    assign busy        = (state_reg != S_IDLE);
    assign jobs_done   = jobs_reg;

endmodule

// File: tb/tb_qc_job_dispatcher.sv
// Directed bench for qc_job_dispatcher. Two instances share clk/rst:
// dut 0 uses default TIMEOUT/JW, dut 1 uses TIMEOUT=16, JW=2.
// A small engine model per instance asserts done a set number of cycles
// after start (0 = never) and drops it on eng_clr.
module tb_qc_job_dispatcher;

    localparam int ND = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  req_valid       [ND];
    logic [7:0]  req_prog        [ND];
    logic [3:0]  req_ready       [ND];
    logic [3:0]  rsp_valid       [ND];
    logic        rsp_status      [ND];
    logic [31:0] rsp_cycles      [ND];
    logic        eng_start       [ND];
    logic [1:0]  eng_prog_id     [ND];
    logic        eng_done        [ND];
    logic [31:0] eng_cycle_count [ND];
    logic        eng_clr         [ND];
    logic        busy            [ND];
    logic [15:0] jobs_done_a;
    logic [1:0]  jobs_done_b;

    qc_job_dispatcher #(.N_REQ(4), .TIMEOUT(4096), .JW(16)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_prog(req_prog[0]),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
        .rsp_status(rsp_status[0]), .rsp_cycles(rsp_cycles[0]),
        .eng_start(eng_start[0]), .eng_prog_id(eng_prog_id[0]),
        .eng_done(eng_done[0]), .eng_cycle_count(eng_cycle_count[0]),
        .eng_clr(eng_clr[0]), .busy(busy[0]), .jobs_done(jobs_done_a)
    );

    qc_job_dispatcher #(.N_REQ(4), .TIMEOUT(16), .JW(2)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_prog(req_prog[1]),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
        .rsp_status(rsp_status[1]), .rsp_cycles(rsp_cycles[1]),
        .eng_start(eng_start[1]), .eng_prog_id(eng_prog_id[1]),
        .eng_done(eng_done[1]), .eng_cycle_count(eng_cycle_count[1]),
        .eng_clr(eng_clr[1]), .busy(busy[1]), .jobs_done(jobs_done_b)
    );

    // Engine model: done goes high eng_delay cycles after the start cycle.
    int unsigned eng_delay  [ND];
    logic        force_done [ND];
    logic        eng_run    [ND];
    logic        done_q     [ND];
    int unsigned eng_cnt    [ND];

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                eng_run[d] <= 1'b0;
                done_q[d]  <= 1'b0;
                eng_cnt[d] <= 0;
            end else if (eng_clr[d]) begin
                eng_run[d] <= 1'b0;
                done_q[d]  <= 1'b0;
            end else if (eng_start[d]) begin
                eng_run[d] <= 1'b1;
                eng_cnt[d] <= 1;
                done_q[d]  <= (eng_delay[d] == 1);
            end else if (eng_run[d] && !done_q[d]) begin
                eng_cnt[d] <= eng_cnt[d] + 1;
                if (eng_cnt[d] + 1 == eng_delay[d]) done_q[d] <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int d = 0; d < ND; d++) begin
            eng_done[d] = done_q[d] | force_done[d];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, filled at each falling edge by tick().
    int          ready_cyc  [ND];
    int          start_cyc  [ND];
    int          clr_cyc    [ND];
    int          rsp_at     [ND];
    int          ready_idx  [ND];
    int          rsp_idx    [ND];
    logic [1:0]  ready_prog [ND];
    int          n_ready    [ND];
    int          n_start    [ND];
    int          n_rsp      [ND];
    logic        rsp_stat   [ND];
    logic [31:0] rsp_val    [ND];
    bit          keep_req   [ND];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            if (req_ready[d] != 4'd0) begin
                check("ready_onehot", 32'($onehot(req_ready[d])), 1);
                ready_cyc[d]  = cyc;
                ready_idx[d]  = idx_of(req_ready[d]);
                ready_prog[d] = eng_prog_id[d];
                n_ready[d]++;
                if (!keep_req[d]) req_valid[d] = req_valid[d] & ~req_ready[d];
            end
            if (eng_start[d]) begin
                start_cyc[d] = cyc;
                n_start[d]++;
            end
            if (eng_clr[d]) clr_cyc[d] = cyc;
            if (rsp_valid[d] != 4'd0) begin
                rsp_at[d]   = cyc;
                rsp_idx[d]  = idx_of(rsp_valid[d]);
                rsp_stat[d] = rsp_status[d];
                rsp_val[d]  = rsp_cycles[d];
                n_rsp[d]++;
                $display("dut%0d rsp req=%0d status=%0d cycles=%0d cyc=%0d",
                         d, rsp_idx[d], rsp_stat[d], rsp_val[d], cyc);
                check("rsp_matches_grant", rsp_idx[d], ready_idx[d]);
            end
        end
    endtask

    task automatic wait_rsp(input int d, input int budget);
        int n0;
        int k;
        n0 = n_rsp[d];
        k  = 0;
        while (n_rsp[d] == n0 && k < budget) begin
            tick();
            k++;
        end
        check("rsp_seen", n_rsp[d] - n0, 1);
    endtask

    task automatic wait_start(input int d, input int budget);
        int n0;
        int k;
        n0 = n_start[d];
        k  = 0;
        while (n_start[d] == n0 && k < budget) begin
            tick();
            k++;
        end
        check("start_seen", n_start[d] - n0, 1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            req_valid[d] = '0; req_prog[d] = '0; eng_delay[d] = 0;
            force_done[d] = 1'b0; eng_cycle_count[d] = '0; keep_req[d] = 1'b0;
            ready_cyc[d] = 0; start_cyc[d] = 0; clr_cyc[d] = 0; rsp_at[d] = 0;
            ready_idx[d] = -1; rsp_idx[d] = -1; ready_prog[d] = '0;
            n_ready[d] = 0; n_start[d] = 0; n_rsp[d] = 0;
            rsp_stat[d] = 1'b0; rsp_val[d] = '0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", busy[0], 0);
        check("rst_req_ready", req_ready[0], 0);
        check("rst_eng_start", eng_start[0], 0);
        check("rst_jobs", jobs_done_a, 0);
        rst = 1'b0;
        tick();

        // Single request 0, prog 2, done 20 cycles after start, count 57
        eng_delay[0] = 20;
        eng_cycle_count[0] = 57;
        t0 = cyc;
        req_prog[0]  = 8'h02;
        req_valid[0] = 4'b0001;
        wait_rsp(0, 100);
        check("t1_ready_lat", ready_cyc[0] - t0, 1);
        check("t1_start_lat", start_cyc[0] - t0, 1);
        check("t1_ready_idx", ready_idx[0], 0);
        check("t1_prog", ready_prog[0], 2);
        check("t1_clr_lat", clr_cyc[0] - start_cyc[0], 21);
        check("t1_rsp_lat", rsp_at[0] - start_cyc[0], 22);
        check("t1_status", rsp_stat[0], 0);
        check("t1_cycles", rsp_val[0], 57);
        tick();
        check("t1_jobs", jobs_done_a, 1);
        check("t1_idle", busy[0], 0);
        check("t1_prog_hold", eng_prog_id[0], 2);

        // Round robin with all four requesting continuously
        pulse_rst();
        keep_req[0]  = 1'b1;
        eng_delay[0] = 3;
        req_valid[0] = 4'hF;
        for (int k = 0; k < 5; k++) begin
            eng_cycle_count[0] = 32'(100 + k);
            wait_rsp(0, 50);
            check("rr_order", ready_idx[0], k % 4);
            check("rr_cycles", rsp_val[0], 32'(100 + k));
        end
        req_valid[0] = '0;
        keep_req[0]  = 1'b0;
        tick();
        check("rr_jobs", jobs_done_a, 5);

        // Engine done held high in IDLE blocks the grant
        force_done[0] = 1'b1;
        req_valid[0]  = 4'b0010;
        t0 = n_ready[0];
        repeat (6) tick();
        check("hold_no_grant", n_ready[0] - t0, 0);
        check("hold_busy", busy[0], 0);
        force_done[0] = 1'b0;
        t0 = cyc;
        wait_rsp(0, 50);
        check("hold_grant_lat", ready_cyc[0] - t0, 1);
        check("hold_grant_idx", ready_idx[0], 1);

        // Reset mid-RUN; pointer returns to 0
        eng_delay[0] = 0;
        req_valid[0] = 4'b0100;
        wait_start(0, 20);
        repeat (3) tick();
        check("pre_rst_busy", busy[0], 1);
        req_valid[0] = 4'b1010;
        t0 = n_rsp[0];
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy[0], 0);
        check("arst_eng_clr", eng_clr[0], 0);
        check("arst_rsp_valid", rsp_valid[0], 0);
        check("arst_prog", eng_prog_id[0], 0);
        check("arst_cycles", rsp_cycles[0], 0);
        check("arst_jobs", jobs_done_a, 0);
        eng_delay[0] = 3;
        tick();
        check("rst_no_rsp", n_rsp[0] - t0, 0);
        rst = 1'b0;
        wait_rsp(0, 50);
        check("post_rst_first", ready_idx[0], 1);
        wait_rsp(0, 50);
        check("post_rst_second", ready_idx[0], 3);
        tick();
        check("post_rst_jobs", jobs_done_a, 2);

        // Timeout on dut 1 (TIMEOUT=16), then a normal job
        eng_delay[1] = 0;
        req_prog[1]  = 8'h01;
        req_valid[1] = 4'b0001;
        wait_rsp(1, 100);
        check("to_prog", ready_prog[1], 1);
        check("to_clr_lat", clr_cyc[1] - start_cyc[1], 17);
        check("to_rsp_lat", rsp_at[1] - start_cyc[1], 18);
        check("to_status", rsp_stat[1], 1);
        check("to_cycles", rsp_val[1], 16);
        tick();
        check("to_status_hold", rsp_status[1], 1);
        eng_delay[1] = 5;
        eng_cycle_count[1] = 99;
        req_prog[1]  = 8'h0C;
        req_valid[1] = 4'b0010;
        wait_rsp(1, 100);
        check("after_to_idx", rsp_idx[1], 1);
        check("after_to_prog", ready_prog[1], 3);
        check("after_to_clr_lat", clr_cyc[1] - start_cyc[1], 6);
        check("after_to_status", rsp_stat[1], 0);
        check("after_to_cycles", rsp_val[1], 99);
        tick();
        check("b_jobs_2", jobs_done_b, 2);

        // Saturation of a 2-bit jobs counter
        eng_delay[1] = 2;
        for (int k = 0; k < 3; k++) begin
            req_valid[1] = 4'b0100;
            wait_rsp(1, 50);
            tick();
            if (k == 0) check("b_jobs_3", jobs_done_b, 3);
        end
        check("b_jobs_sat", jobs_done_b, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
